// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
// Holds the state encoding, default widths and the latency limits.
package dmem_pkg;

  localparam int DMEM_DATA_W      = 32;
  localparam int DMEM_ADDR_W      = 8;
  localparam int DMEM_MAX_LATENCY = 15;
  localparam int DMEM_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter preload on acceptance: BUSY lasts LATENCY-1 cycles, counted down to zero.
  function automatic logic [DMEM_CNT_W-1:0] busy_load(input int latency);
    int lat_c;
    lat_c = (latency > DMEM_MAX_LATENCY) ? DMEM_MAX_LATENCY : latency;
    return (lat_c >= 2) ? DMEM_CNT_W'(lat_c - 2) : '0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// EX/MEM-side data-memory bus: request fields from the pipeline,
// response, stall and error back from the memory target.
interface dmem_responder_if #(
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W
) ();

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              resp_valid;
  logic              hold;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, write_data,
    input  read_data, resp_valid, hold, err
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data,
    output read_data, resp_valid, hold, err
  );

endinterface

// File: rtl/dmem_latency_ctr.sv
// Loadable 4-bit down-counter; o_done flags the last BUSY cycle
// (counter at zero while enabled).
module dmem_latency_ctr
  import dmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [DMEM_CNT_W-1:0] i_load_val,
  input  logic                  i_en,
  output logic                  o_done
);

  logic [DMEM_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls EX/MEM for LATENCY cycles, then
// commits a store or returns load data. Define DMEM_PERF_CNT_EN for perf counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int LATENCY = 3
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count,
  output logic [31:0]     stall_count
`endif
);

  localparam int                    DEPTH        = 2 ** ADDR_W;
  localparam bit                    SINGLE_CYCLE = (LATENCY == 1);
  localparam logic [DMEM_CNT_W-1:0] LOAD_VAL     = busy_load(LATENCY);

  state_t            r_state;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_read_data;
  logic              r_resp_valid;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_idle;
  logic              w_busy;
  logic              w_req_one;
  logic              w_req_bad;
  logic              w_accept;
  logic              w_done;
  logic              w_hold;
  logic              w_commit;
  logic              w_commit_wr;
  logic [ADDR_W-1:0] w_commit_addr;
  logic [DATA_W-1:0] w_commit_data;

  assign w_idle    = (r_state == IDLE);
  assign w_busy    = (r_state == BUSY);
  assign w_req_one = bus.mem_read ^ bus.mem_write;
  assign w_req_bad = bus.mem_read & bus.mem_write;
  assign w_accept  = w_idle & w_req_one;
  assign w_hold    = w_accept | w_busy;

  // With LATENCY==1 the commit edge is the acceptance edge, so the live
  // request fields are used instead of the (not yet loaded) latches.
  assign w_commit      = (w_accept & SINGLE_CYCLE) | (w_busy & w_done);
  assign w_commit_wr   = w_idle ? bus.mem_write : r_is_write;
  assign w_commit_addr = w_idle ? bus.addr : r_addr;
  assign w_commit_data = w_idle ? bus.write_data : r_wdata;

  dmem_latency_ctr u_latency_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_en       (w_busy),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_read_data  <= '0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= w_commit;
      r_err        <= w_idle & w_req_bad;
      if (w_commit && !w_commit_wr) begin
        r_read_data <= r_mem[w_commit_addr];
      end
      case (r_state)
        IDLE: begin
          if (w_req_one) begin
            r_is_write <= bus.mem_write;
            r_addr     <= bus.addr;
            r_wdata    <= bus.write_data;
            r_state    <= SINGLE_CYCLE ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state <= RESP;
          end
        end
        // The request is still sitting in EX/MEM here and must not retrigger.
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit && w_commit_wr) begin
      r_mem[w_commit_addr] <= w_commit_data;
    end
  end

  assign bus.hold       = w_hold;
  assign bus.read_data  = r_read_data;
  assign bus.resp_valid = r_resp_valid;
  assign bus.err        = r_err;

`ifdef DMEM_PERF_CNT_EN
  // Bit order: load commits, store commits, stall cycles.
  logic [2:0] w_perf_inc;
  assign w_perf_inc = {w_hold, w_commit & w_commit_wr, w_commit & ~w_commit_wr};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] r_cnt;
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (w_perf_inc[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign rd_count    = g_perf[0].r_cnt;
  assign wr_count    = g_perf[1].r_cnt;
  assign stall_count = g_perf[2].r_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random accesses on a LATENCY=3 and a
// LATENCY=1 instance, checked against a transaction-level memory model.
module tb_dmem_responder;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] m_mem [2][256];
  logic [31:0] m_rd  [2];

  dmem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
  dmem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_count0, wr_count0, stall_count0;
  logic [31:0] rd_count1, wr_count1, stall_count1;
`endif

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT0)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus0)
`ifdef DMEM_PERF_CNT_EN
    ,
    .rd_count    (rd_count0),
    .wr_count    (wr_count0),
    .stall_count (stall_count0)
`endif
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus1)
`ifdef DMEM_PERF_CNT_EN
    ,
    .rd_count    (rd_count1),
    .wr_count    (wr_count1),
    .stall_count (stall_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.write_data = d;
    end else begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.write_data = d;
    end
  endtask

  function automatic logic [31:0] g_hold(input int sel);
    return (sel == 0) ? 32'(bus0.hold) : 32'(bus1.hold);
  endfunction
  function automatic logic [31:0] g_resp(input int sel);
    return (sel == 0) ? 32'(bus0.resp_valid) : 32'(bus1.resp_valid);
  endfunction
  function automatic logic [31:0] g_err(input int sel);
    return (sel == 0) ? 32'(bus0.err) : 32'(bus1.err);
  endfunction
  function automatic logic [31:0] g_rdata(input int sel);
    return (sel == 0) ? bus0.read_data : bus1.read_data;
  endfunction

  // One clock cycle: inputs change just after the rising edge, outputs are
  // sampled at the following falling edge.
  task automatic cycle(input int sel, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    drive(sel, rd, wr, a, d);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_rd[s] = '0;
      for (int i = 0; i < 256; i++) m_mem[s][i] = '0;
    end
  endtask

  task automatic idle(input int sel);
    cycle(sel, 1'b0, 1'b0, 8'h00, 32'h0);
    check("idle_hold", g_hold(sel), 32'd0);
    check("idle_resp", g_resp(sel), 32'd0);
  endtask

  // Request stays on the bus while hold is high; keep leaves it on through RESP.
  task automatic access(input int sel, input bit is_wr, input logic [7:0] a,
                        input logic [31:0] d, input bit keep);
    int lat;
    lat = (sel == 0) ? LAT0 : LAT1;
    for (int k = 0; k < lat; k++) begin
      cycle(sel, !is_wr, is_wr, a, d);
      check("hold_stall", g_hold(sel), 32'd1);
      check("resp_early", g_resp(sel), 32'd0);
    end
    if (is_wr) m_mem[sel][a] = d;
    else       m_rd[sel] = m_mem[sel][a];
    if (keep) cycle(sel, !is_wr, is_wr, a, d);
    else      cycle(sel, 1'b0, 1'b0, 8'h00, 32'h0);
    check("hold_resp", g_hold(sel), 32'd0);
    check("resp_valid", g_resp(sel), 32'd1);
    check("read_data", g_rdata(sel), m_rd[sel]);
    $display("access dut=%0d %s addr=%02h wdata=%08h read_data=%08h keep=%0d",
             sel, is_wr ? "store" : "load ", a, d, g_rdata(sel), keep);
  endtask

  task automatic illegal(input int sel, input logic [7:0] a, input logic [31:0] d);
    cycle(sel, 1'b1, 1'b1, a, d);
    check("illegal_hold", g_hold(sel), 32'd0);
    check("illegal_err_early", g_err(sel), 32'd0);
    cycle(sel, 1'b0, 1'b0, 8'h00, 32'h0);
    check("illegal_err", g_err(sel), 32'd1);
    check("illegal_resp", g_resp(sel), 32'd0);
    cycle(sel, 1'b0, 1'b0, 8'h00, 32'h0);
    check("illegal_err_clear", g_err(sel), 32'd0);
    $display("illegal dut=%0d addr=%02h", sel, a);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [31:0] rdat;
    bit          rw;
    bit          rkeep;

    total = 0;
    bad   = 0;
    model_reset();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_hold", g_hold(s), 32'd0);
      check("rst_resp", g_resp(s), 32'd0);
      check("rst_err", g_err(s), 32'd0);
      check("rst_rdata", g_rdata(s), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);

    // LATENCY=1: hold only in the request cycle, response the next cycle.
    access(1, 1'b1, 8'h03, 32'hA5A5_5A5A, 1'b0);
    access(1, 1'b0, 8'h03, 32'h0, 1'b1);
    access(1, 1'b0, 8'h07, 32'h0, 1'b0);
    idle(1);

    // LATENCY=3 store then load.
    access(0, 1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 8'h05, 32'h0, 1'b0);
    illegal(0, 8'h05, 32'h0BAD_F00D);
    access(0, 1'b0, 8'h05, 32'h0, 1'b0);

    // Request held through RESP, then a new load the very next cycle.
    access(0, 1'b1, 8'h30, 32'hCAFE_0030, 1'b1);
    access(0, 1'b0, 8'h30, 32'h0, 1'b0);
    idle(0);

    for (int n = 0; n < 40; n++) begin
      rw    = 1'($urandom_range(0, 1));
      ra    = 8'($urandom_range(0, 15));
      rdat  = $urandom;
      rkeep = (n == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      access(0, rw, ra, rdat, rkeep);
      if (!rkeep && ($urandom_range(0, 3) == 0)) illegal(0, ra, $urandom);
      else if (!rkeep) idle(0);
    end

    // Reset in BUSY: the pending store to 0x10 must be dropped.
    cycle(0, 1'b0, 1'b1, 8'h10, 32'h1234_5678);
    check("rstbusy_hold0", g_hold(0), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstbusy_hold1", g_hold(0), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    model_reset();
    @(negedge clk);
    check("rstbusy_hold_after", g_hold(0), 32'd0);
    check("rstbusy_resp_after", g_resp(0), 32'd0);
    check("rstbusy_rdata_after", g_rdata(0), 32'd0);
    idle(0);
    access(0, 1'b1, 8'h20, 32'h1111_2222, 1'b0);
    access(0, 1'b1, 8'h21, 32'h3333_4444, 1'b0);
    access(0, 1'b0, 8'h10, 32'h0, 1'b0);
    idle(0);
`ifdef DMEM_PERF_CNT_EN
    check("wr_count", wr_count0, 32'd2);
    check("rd_count", rd_count0, 32'd1);
    check("stall_count", stall_count0, 32'd9);
`endif
    access(0, 1'b0, 8'h21, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
